// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF input synchronizer, internal baud counter with mid-bit
// sampling, configurable data width, parity and stop bits; one-cycle valid per frame.
module uart_rx_core #(
  parameter int P_CLK_FREQ    = 50_000_000,
  parameter int P_BAUD        = 115200,
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_PARITY_TYPE = 0,
  parameter int P_STOP_WIDTH  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rx,
  output logic [P_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                    o_user_rx_valid,
  output logic                    o_parity_err,
  output logic                    o_frame_err
);

  localparam int DIV   = P_CLK_FREQ / P_BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(DIV / 2);
  localparam logic [3:0]       DATA_LAST  = 4'(P_DATA_WIDTH - 1);
  localparam logic [3:0]       STOP_LAST  = 4'(P_STOP_WIDTH - 1);
  localparam bit               HAS_PARITY = (P_PARITY_TYPE != 0);
  localparam logic             ODD_PARITY = 1'(P_PARITY_TYPE == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                    arm_q, arm_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    valid_q, valid_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_err_q, frame_err_d;

  logic rx_s;
  logic mid;
  assign rx_s = sync_q[1];
  assign mid  = (cnt_q == CNT_MID);

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch of the case below can infer a latch.
    sync_d       = {sync_q[0], i_rx};
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    arm_d        = arm_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    valid_d      = 1'b0;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (state_q != S_IDLE) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        arm_d = arm_q | rx_s;
        // This cycle is T0 with the counter at 0, so the next cycle reads 1.
        if (arm_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = CNT_W'(1);
          bit_d   = '0;
          arm_d   = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (mid) begin
          if (rx_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {rx_s, shift_q[P_DATA_WIDTH-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (mid) begin
          perr_d  = rx_s ^ (^shift_q) ^ ODD_PARITY;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          if (!rx_s) ferr_d = 1'b1;
          // Leave at mid-bit so a start edge right after the stop bit is not missed.
          if (bit_q == STOP_LAST) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            bit_d        = '0;
            valid_d      = 1'b1;
            data_d       = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q | ~rx_s;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (i_rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      arm_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      arm_q        <= arm_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_user_rx_data  = data_q;
  assign o_user_rx_valid = valid_q;
  assign o_parity_err    = parity_err_q;
  assign o_frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: an 8N1 instance and an 8E1 instance,
// scoreboard queues filled at stimulus time and drained by valid-pulse monitors.
module tb_uart_rx_core;

  localparam int DIV = 434;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   last_valid_cyc_a = 0;
  int   n_valid_a = 0;
  int   n_valid_b = 0;
  logic prev_valid_a = 1'b0;
  logic prev_valid_b = 1'b0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core #(
    .P_CLK_FREQ(50_000_000), .P_BAUD(115200), .P_DATA_WIDTH(8),
    .P_PARITY_TYPE(0), .P_STOP_WIDTH(1)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a),
    .o_user_rx_data(data_a), .o_user_rx_valid(valid_a),
    .o_parity_err(perr_a), .o_frame_err(ferr_a)
  );

  uart_rx_core #(
    .P_CLK_FREQ(50_000_000), .P_BAUD(115200), .P_DATA_WIDTH(8),
    .P_PARITY_TYPE(2), .P_STOP_WIDTH(1)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_b),
    .o_user_rx_data(data_b), .o_user_rx_valid(valid_b),
    .o_parity_err(perr_b), .o_frame_err(ferr_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic expect_a(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    sb_a.push_back(e);
  endtask

  task automatic expect_b(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    sb_b.push_back(e);
  endtask

  // Entered and left #1 after a posedge; holds the level for len cycles.
  task automatic drive_bit(input bit sel, input logic v, input int len);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input int len);
    t_start = cyc;
    drive_bit(sel, 1'b0, len);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], len);
    if (par_en) drive_bit(sel, par_bit, len);
    drive_bit(sel, 1'b1, len);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_a) begin
      n_valid_a++;
      last_valid_cyc_a = cyc;
      check("a_valid_width", {31'd0, prev_valid_a}, 32'd0);
      if (sb_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = sb_a.pop_front();
        check("a_data", {24'd0, data_a}, {24'd0, e.data});
        check("a_parity_err", {31'd0, perr_a}, {31'd0, e.perr});
        check("a_frame_err", {31'd0, ferr_a}, {31'd0, e.ferr});
      end
    end
    if (valid_b) begin
      n_valid_b++;
      check("b_valid_width", {31'd0, prev_valid_b}, 32'd0);
      if (sb_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = sb_b.pop_front();
        check("b_data", {24'd0, data_b}, {24'd0, e.data});
        check("b_parity_err", {31'd0, perr_b}, {31'd0, e.perr});
        check("b_frame_err", {31'd0, ferr_b}, {31'd0, e.ferr});
      end
    end
    prev_valid_a = valid_a;
    prev_valid_b = valid_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    check("rst_data_a", {24'd0, data_a}, 32'd0);
    check("rst_valid_a", {31'd0, valid_a}, 32'd0);
    check("rst_perr_a", {31'd0, perr_a}, 32'd0);
    check("rst_ferr_a", {31'd0, ferr_a}, 32'd0);
    check("rst_data_b", {24'd0, data_b}, 32'd0);
    idle_cycles(5);

    // Basic 8N1 frame and its exact latency from the line falling edge.
    expect_a(8'h55, 1'b0, 1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, DIV);
    check("t1_valid_count", n_valid_a, 32'd1);
    check("t1_latency", last_valid_cyc_a - t_start, 32'(2 + 9 * DIV + DIV / 2 + 1));

    // Short glitch is a false start.
    v0 = n_valid_a;
    rx_a = 1'b0;
    idle_cycles(100);
    rx_a = 1'b1;
    idle_cycles(3 * DIV);
    check("t3_no_valid", n_valid_a, v0);
    check("t3_data_held", {24'd0, data_a}, 32'h55);

    // Back-to-back frames with no idle gap.
    v0 = n_valid_a;
    expect_a(8'h00, 1'b0, 1'b0);
    expect_a(8'hFF, 1'b0, 1'b0);
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, DIV);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, DIV);
    check("t4_valid_count", n_valid_a, v0 + 2);

    // Break: one valid with frame error, then nothing until the line idles high.
    v0 = n_valid_a;
    expect_a(8'h00, 1'b0, 1'b1);
    rx_a = 1'b0;
    idle_cycles(20 * DIV);
    check("t5_break_count", n_valid_a, v0 + 1);
    check("t5_break_ferr", {31'd0, ferr_a}, 32'd1);
    rx_a = 1'b1;
    idle_cycles(2 * DIV);
    check("t5_idle_count", n_valid_a, v0 + 1);
    expect_a(8'h3C, 1'b0, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, DIV);
    check("t5_recover_count", n_valid_a, v0 + 2);

    // +/-2% line rate.
    v0 = n_valid_a;
    expect_a(8'hC3, 1'b0, 1'b0);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 443);
    idle_cycles(DIV);
    expect_a(8'hA5, 1'b0, 1'b0);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 425);
    idle_cycles(DIV);
    check("tol_valid_count", n_valid_a, v0 + 2);

    // Even parity on the second instance.
    expect_b(8'hA3, 1'b1, 1'b0);
    send_frame(1'b1, 8'hA3, 1'b1, 1'b1, DIV);
    expect_b(8'hA3, 1'b0, 1'b0);
    send_frame(1'b1, 8'hA3, 1'b1, 1'b0, DIV);
    expect_b(8'h07, 1'b1, 1'b0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, DIV);
    check("t2_valid_count", n_valid_b, 32'd3);

    // Reset during data bit 4 of 0x96; the sender abandons the frame.
    v0 = n_valid_a;
    drive_bit(1'b0, 1'b0, DIV);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'(8'h96 >> i), DIV);
    rx_a = 1'b1;
    idle_cycles(200);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(2 * DIV);
    check("t6_no_valid", n_valid_a, v0);
    check("t6_data_zero", {24'd0, data_a}, 32'd0);
    check("t6_ferr_zero", {31'd0, ferr_a}, 32'd0);
    check("t6_perr_zero", {31'd0, perr_a}, 32'd0);
    expect_a(8'h5A, 1'b0, 1'b0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, DIV);
    check("t6_recover_count", n_valid_a, v0 + 1);

    idle_cycles(DIV);
    check("sb_a_drained", sb_a.size(), 32'd0);
    check("sb_b_drained", sb_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
